// File: rtl/asym_row_fifo.sv
// Asymmetric FIFO: DW-bit entries in, RATIO entries packed per read word (oldest in lane 0).
// Optional macro ASYM_ROW_FIFO_OUT_REG_EN adds a second output register (read latency 2 instead of 1).
module asym_row_fifo #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DW-1:0]            w_data,
  input  logic                     r_en,
  output logic                     r_avail,
  output logic [DW*RATIO-1:0]      r_data,
  output logic                     r_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                w_acc;
  logic                r_acc;
  logic [DW*RATIO-1:0] rd_word;
  logic [DW*RATIO-1:0] rd_data1;
  logic                rd_valid1;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign w_ready = !full;
  assign r_avail = (count >= CW'(RATIO));
  assign w_acc   = w_valid && !full;
  assign r_acc   = r_en && r_avail;

  always_ff @(posedge clk) begin
    if (w_acc) mem[wr_ptr] <= w_data;
  end

  // rd_ptr is always word-aligned, so OR-ing the lane index never carries.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      rd_word[i*DW +: DW] = mem[rd_ptr | AW'(i)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
      rd_valid1 <= 1'b0;
      rd_data1  <= '0;
    end else begin
      if (w_acc) wr_ptr <= wr_ptr + AW'(1);
      if (r_acc) rd_ptr <= rd_ptr + AW'(RATIO);
      count     <= count + CW'(w_acc) - (r_acc ? CW'(RATIO) : CW'(0));
      err       <= err | (w_valid && full) | (r_en && !r_avail);
      rd_valid1 <= r_acc;
      if (r_acc) rd_data1 <= rd_word;
    end
  end

`ifdef ASYM_ROW_FIFO_OUT_REG_EN
  logic [DW*RATIO-1:0] rd_data2;
  logic                rd_valid2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid2 <= 1'b0;
      rd_data2  <= '0;
    end else begin
      rd_valid2 <= rd_valid1;
      if (rd_valid1) rd_data2 <= rd_data1;
    end
  end

  assign r_data  = rd_data2;
  assign r_valid = rd_valid2;
`else
  assign r_data  = rd_data1;
  assign r_valid = rd_valid1;
`endif

endmodule

// File: tb/tb_asym_row_fifo.sv
// Bench for asym_row_fifo: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_asym_row_fifo;
  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int DEPTH = 16;
`ifdef ASYM_ROW_FIFO_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  w_data;
  logic        r_en;
  logic        r_avail;
  logic [31:0] r_data;
  logic        r_valid;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        err;

  asym_row_fifo #(.DW(DW), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .r_en(r_en), .r_avail(r_avail), .r_data(r_data), .r_valid(r_valid),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO is a byte queue; a read pops the four oldest bytes.
  logic [7:0]  mq[$];
  bit          m_err;
  bit          sv[LAT];
  logic [31:0] sd[LAT];
  bit          m_racc;
  bit          m_wacc;
  logic [31:0] m_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
      for (int i = 0; i < LAT; i++) begin
        sv[i] = 1'b0;
        sd[i] = '0;
      end
    end else begin
      m_racc = r_en && (mq.size() >= RATIO);
      m_wacc = w_valid && (mq.size() < DEPTH);
      if (r_en && !(mq.size() >= RATIO)) m_err = 1'b1;
      if (w_valid && (mq.size() >= DEPTH)) m_err = 1'b1;
      m_word = sd[0];
      if (m_racc) begin
        m_word = {mq[3], mq[2], mq[1], mq[0]};
        repeat (RATIO) void'(mq.pop_front());
      end
      if (m_wacc) mq.push_back(w_data);
      for (int i = LAT - 1; i > 0; i--) begin
        if (sv[i-1]) sd[i] = sd[i-1];
        sv[i] = sv[i-1];
      end
      sv[0] = m_racc;
      sd[0] = m_word;
    end
  end

  always @(negedge clk) begin
    chk("count",   32'(count),   32'(mq.size()));
    chk("full",    32'(full),    32'(mq.size() == DEPTH));
    chk("empty",   32'(empty),   32'(mq.size() == 0));
    chk("w_ready", 32'(w_ready), 32'(mq.size() < DEPTH));
    chk("r_avail", 32'(r_avail), 32'(mq.size() >= RATIO));
    chk("err",     32'(err),     32'(m_err));
    chk("r_valid", 32'(r_valid), 32'(sv[LAT-1]));
    chk("r_data",  r_data,       sd[LAT-1]);
  end

  task automatic cyc(input bit wv, input logic [7:0] wd, input bit re);
    w_valid = wv;
    w_data  = wd;
    r_en    = re;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    r_en    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  int wprob;

  initial begin
    w_valid = 1'b0;
    r_en    = 1'b0;
    w_data  = '0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    chk("rst_r_avail", 32'(r_avail), 32'd0);

    // Basic packing order
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    cyc(0, 8'h00, 1);
    chk("rd_count0", 32'(count), 32'd0);
    idle(LAT - 1);
    chk("rd_valid", 32'(r_valid), 32'd1);
    chk("rd_word",  r_data,       32'h44332211);
    idle(1);
    chk("rd_pulse", 32'(r_valid), 32'd0);
    chk("rd_hold",  r_data,       32'h44332211);

    // Fill and overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hA0 + i), 0);
    chk("full_count", 32'(count),   32'd16);
    chk("full_flag",  32'(full),    32'd1);
    chk("full_wrdy",  32'(w_ready), 32'd0);
    chk("full_err0",  32'(err),     32'd0);
    cyc(1, 8'hEE, 0);
    chk("ovf_err",    32'(err),     32'd1);
    chk("ovf_count",  32'(count),   32'd16);

    // Underflow
    do_reset();
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0);
    cyc(0, 8'h00, 1);
    chk("udf_count", 32'(count), 32'd3);
    chk("udf_err",   32'(err),   32'd1);
    idle(LAT);
    chk("udf_valid", 32'(r_valid), 32'd0);

    // Write-pointer wrap
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1, 8'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    for (int i = 12; i < 24; i++) cyc(1, 8'(i), 0);
    cyc(0, 8'h00, 1); idle(LAT - 1);
    chk("wrap_w0", r_data, 32'h0F0E0D0C);
    cyc(0, 8'h00, 1); idle(LAT - 1);
    chk("wrap_w1", r_data, 32'h13121110);
    cyc(0, 8'h00, 1); idle(LAT - 1);
    chk("wrap_w2", r_data, 32'h17161514);

    // Simultaneous write and read at count=4
    do_reset();
    cyc(1, 8'hA1, 0); cyc(1, 8'hB2, 0); cyc(1, 8'hC3, 0); cyc(1, 8'hD4, 0);
    cyc(1, 8'hE5, 1);
    chk("wr_rd_count", 32'(count), 32'd1);
    idle(LAT - 1);
    chk("wr_rd_word", r_data, 32'hD4C3B2A1);

    // Reset while a read is in flight
    do_reset();
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    cyc(0, 8'h00, 1);
    rst = 1'b1;
    #1;
    chk("rst_fl_valid", 32'(r_valid), 32'd0);
    chk("rst_fl_count", 32'(count),   32'd0);
    chk("rst_fl_err",   32'(err),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with varying write pressure
    for (int seg = 0; seg < 6; seg++) begin
      wprob = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 6 : 10);
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        else cyc(($urandom_range(0, 9) < wprob), 8'($urandom), ($urandom_range(0, 9) < 3));
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/asym_row_fifo.md
ASYM_ROW_FIFO -- requirements
Module: asym_row_fifo

Interface
REQ-001 SHALL have parameter DW, default 8: write-side entry width in bits.
REQ-002 SHALL have parameter RATIO, default 4: entries packed per read word; power of 2, at least 2.
REQ-003 SHALL have parameter DEPTH, default 2048: storage in DW-bit entries; power of 2, multiple of RATIO.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port w_valid, input, 1 bit: write request.
REQ-007 SHALL have port w_ready, output, 1 bit: write accepted this cycle if w_valid is high.
REQ-008 SHALL have port w_data, input, DW bits: entry to store.
REQ-009 SHALL have port r_en, input, 1 bit: request to pop one packed word.
REQ-010 SHALL have port r_avail, output, 1 bit: at least RATIO entries are stored.
REQ-011 SHALL have port r_data, output, DW*RATIO bits: packed read word.
REQ-012 SHALL have port r_valid, output, 1 bit: r_data is valid this cycle (one-cycle pulse per accepted read).
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: entries currently stored.
REQ-014 SHALL have ports full and empty, output, 1 bit each: count==DEPTH and count==0.
REQ-015 SHALL have port err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-016 SHALL set w_ready = !full, derived from registered count only.
REQ-017 SHALL accept a write when w_valid && !full; it stores w_data at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 SHALL accept a read when r_en && r_avail; it reads RATIO entries at word index rd_ptr/RATIO, and rd_ptr advances by RATIO modulo DEPTH.
REQ-019 SHALL pack the oldest entry into r_data[DW-1:0] and the newest into the most significant lane.
REQ-020 SHALL register r_data and assert r_valid one cycle after the accepted read; r_data SHALL hold its value otherwise.
REQ-021 SHALL update count by +1 per accepted write and -RATIO per accepted read; when both occur in one cycle, count SHALL change by 1-RATIO.
REQ-022 SHALL reject a write at full (not stored, no pointer change) and set err.
REQ-023 SHALL ignore r_en while !r_avail (no pointer or count change, no r_valid) and set err.
REQ-024 SHALL never read an entry written in the same cycle, because a read only covers entries counted before that cycle; no read-during-write bypass is required.
REQ-025 SHALL keep rd_ptr word-aligned at all times; wr_ptr may be unaligned.

Reset
REQ-026 SHALL asynchronously clear wr_ptr, rd_ptr, count, r_data, r_valid and err on rst high, giving empty=1, full=0, w_ready=1, r_avail=0.
REQ-027 SHALL leave memory contents unreset; rst asserted mid-operation SHALL deassert a pending r_valid immediately.

Configuration
REQ-028 With macro ASYM_ROW_FIFO_OUT_REG_EN defined, SHALL add a second r_data/r_valid register stage, giving read latency 2 with pointer and count timing unchanged.
REQ-029 Without ASYM_ROW_FIFO_OUT_REG_EN, read latency SHALL be 1 cycle.

Verification (DW=8, RATIO=4, DEPTH=16, macro off)
REQ-030 Write 0x11,0x22,0x33,0x44, then pulse r_en -> next cycle r_data=0x44332211, r_valid=1 for exactly one cycle, count=0.
REQ-031 Write 16 entries -> count=16, full=1, w_ready=0; 17th write dropped, err=1, count stays 16.
REQ-032 With count=3, pulse r_en -> no r_valid, count stays 3, err=1.
REQ-033 Write 0x00..0x0B, read 3 words, then write 0x0C..0x17 so wr_ptr wraps -> subsequent reads return 0x0F0E0D0C, 0x13121110, 0x17161514.
REQ-034 At count=4, assert a write and r_en in the same cycle -> count=1, read word equals the 4 prior entries.
REQ-035 Assert rst between an accepted r_en and its r_valid -> r_valid stays 0, count=0, err=0; macro on: REQ-030 stimulus gives r_valid 2 cycles after r_en.
